somatorio_acc: RTL and testbench
================================

# somatorio_acc

Sequencing accumulator that drives the summation step counter. On `start` it presets the counter, then accepts exactly `N_OPS` operands over a valid/ready handshake and adds them into a running sum. It issues one counter decrement per operand except the last, and checks the counter's zero flag at the end as a consistency check. It sits directly upstream of the step counter: it produces that counter's `set`/`dec` inputs and consumes its zero flag.

## Interface
- `DATA_W`, default 8: operand width.
- `SUM_W`, default 12: accumulator and result width. Must be ≥ `DATA_W + clog2(N_OPS)`; a smaller value wraps modulo 2^SUM_W.
- `N_OPS`, default 8: operands per run. The counter preset equals `N_OPS-1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; honoured only in IDLE or DONE.
- `in_valid`  in  1  operand valid.
- `in_data`  in  DATA_W  operand, unsigned.
- `in_ready`  out  1  operand accepted when `in_valid && in_ready`.
- `cnt_set`  out  1  counter preset pulse.
- `cnt_dec`  out  1  counter decrement pulse.
- `cnt_zero`  in  1  counter zero flag.
- `sum`  out  SUM_W  result, held until the next run completes.
- `done`  out  1  result valid.
- `busy`  out  1  run in progress (LOAD/ACCUM/CHECK).
- `err`  out  1  counter zero flag was low at CHECK; held with `done`.

## Operation
- Reset values: state IDLE; acc = 0, op_cnt = 0; `sum`, `done`, `err`, `busy`, `in_ready`, `cnt_set`, `cnt_dec` all 0.
- Reset mid-run abandons the run immediately. The counter itself has no reset, so every run starts with `cnt_set`.
- State machine (one-hot or encoded, from package):
  - **IDLE**: `start` → LOAD.
  - **LOAD**:
    - `cnt_set` = 1 for exactly this cycle.
    - acc ← 0, op_cnt ← 0, `done` ← 0, `err` ← 0.
    - Always → ACCUM.
  - **ACCUM**:
    - `in_ready` = 1.
    - On accept: acc ← acc + zero-extended `in_data`, wrapping modulo 2^SUM_W; op_cnt ← op_cnt + 1.
    - Accepts 1 … N_OPS-1 each produce one `cnt_dec` pulse in the following cycle (registered). Accept N_OPS produces no pulse.
    - Accept N_OPS → CHECK.
    - Without `in_valid`, stay in ACCUM indefinitely.
  - **CHECK**:
    - `in_ready` = 0.
    - Sample `cnt_zero`; `err` ← ~`cnt_zero`; `sum` ← acc.
    - → DONE.
  - **DONE**:
    - `done` = 1; `sum` and `err` held.
    - `start` → LOAD; `done` drops as LOAD is entered.
- `start` in LOAD/ACCUM/CHECK is ignored (no queueing).
- `cnt_zero` is ignored outside CHECK.
- `busy` = 1 in LOAD, ACCUM and CHECK.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from input to output.
- `start` sampled high at edge T:
  - LOAD in cycle T+1 (`cnt_set` high).
  - ACCUM from T+2 (`in_ready` high).
- Back-to-back operands accepted at T+2 … T+N_OPS+1; CHECK at T+N_OPS+2; `done` high from T+N_OPS+3.
  - Default `N_OPS` = 8: `done` at T+11.
- `cnt_dec` pulses occur at T+3 … T+N_OPS+1 for back-to-back input. The final decrement therefore lands one cycle before CHECK, giving the counter one cycle to assert zero.
- Each idle cycle (`in_valid` low) in ACCUM delays every later event by one cycle.
- Throughput: one operand per cycle; runs are separated by at least 3 cycles (CHECK, DONE, LOAD).

## Structure
- Shared package `somatorio_pkg` holds:
  - state typedef (IDLE, LOAD, ACCUM, CHECK, DONE);
  - default widths `DATA_W`/`SUM_W`/`N_OPS`;
  - helper constant `CNT_PRESET = N_OPS-1`, shared with the step counter.
- No sub-module is required. FSM, accumulator and op counter are inline in one module. The step counter remains a separate block instantiated beside it at the top level.

## Test plan
- Reset, then `start`; feed 1,2,…,8 back-to-back; correct counter model attached. Required: `sum` = 36, `done` at T+11, `err` = 0, exactly 7 `cnt_dec` pulses, 1 `cnt_set` pulse.
- Eight operands of 255. Required: `sum` = 2040, no wrap. Second run with `SUM_W` = 10. Required: `sum` = 2040 mod 1024 = 1016.
- Operands 5,5,…,5 with `in_valid` low every other cycle. Required: `sum` = 40; `done` delayed by 7 cycles versus back-to-back; no accept while `in_valid` low.
- Counter model preset to 9 instead of 7. Required: `cnt_zero` low at CHECK, `err` = 1 with `done` = 1, `sum` still correct.
- Reset asserted after 3 accepts. Required: all outputs 0 immediately, IDLE. A fresh run of 8×1 then gives `sum` = 8.
- `start` pulsed during ACCUM: ignored, no extra `cnt_set`. `start` in DONE: `done` falls next cycle, `cnt_set` pulses, new run completes normally.

Source files
------------

// File: rtl/somatorio_pkg.sv
// Shared definitions for the summation accumulator and its step counter:
// FSM state encoding, default widths and the counter preset helper.
package somatorio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ACCUM = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SUM_W  = 12;
    localparam int DEF_N_OPS  = 8;

    // The step counter is preset to one less than the operand count.
    localparam int CNT_PRESET = DEF_N_OPS - 1;

    function automatic int cnt_preset(input int n_ops);
        return n_ops - 1;
    endfunction

endpackage

// File: rtl/somatorio_acc.sv
// Sequencing accumulator: presets the step counter, sums N_OPS operands over a
// valid/ready handshake and cross-checks the counter zero flag at the end.
module somatorio_acc
    import somatorio_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int N_OPS  = DEF_N_OPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cnt_set,
    output logic              cnt_dec,
    input  logic              cnt_zero,
    output logic [SUM_W-1:0]  sum,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int OPC_W = $clog2(N_OPS + 1);
    localparam logic [OPC_W-1:0] LAST_IDX = OPC_W'(cnt_preset(N_OPS));

    state_t             state;
    state_t             next_state;
    logic [SUM_W-1:0]   acc;
    logic [OPC_W-1:0]   op_cnt;
    logic               accept;
    logic               last_accept;

    assign accept      = in_valid && (state == ACCUM);
    assign last_accept = accept && (op_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = ACCUM;
            ACCUM:   if (last_accept) next_state = CHECK;
            CHECK:   next_state = DONE;
            DONE:    if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cnt_set  = 1'b0;
        done     = 1'b0;
        busy     = 1'b0;
        case (state)
            LOAD: begin
                cnt_set = 1'b1;
                busy    = 1'b1;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            CHECK:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The last accept skips its decrement so the counter lands on zero
    // exactly one cycle before CHECK samples the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            op_cnt  <= '0;
            sum     <= '0;
            err     <= 1'b0;
            cnt_dec <= 1'b0;
        end else begin
            cnt_dec <= accept && !last_accept;
            case (state)
                LOAD: begin
                    acc    <= '0;
                    op_cnt <= '0;
                    err    <= 1'b0;
                end
                ACCUM: begin
                    if (accept) begin
                        acc    <= acc + SUM_W'(in_data);
                        op_cnt <= op_cnt + OPC_W'(1);
                    end
                end
                CHECK: begin
                    err <= ~cnt_zero;
                    sum <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_somatorio_acc.sv
// Bench for somatorio_acc with a behavioural step counter attached and a
// scoreboard of expected run results.
module tb_somatorio_acc;
    import somatorio_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, cnt_set, cnt_dec, busy, done, err;
    logic [11:0] sum;
    logic        in_ready_b, cnt_set_b, cnt_dec_b, busy_b, done_b, err_b;
    logic [9:0]  sum_b;
    logic        cnt_zero;

    always #5 clk = ~clk;

    somatorio_acc dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cnt_set(cnt_set), .cnt_dec(cnt_dec), .cnt_zero(cnt_zero),
        .sum(sum), .done(done), .busy(busy), .err(err)
    );

    somatorio_acc #(.SUM_W(10)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .cnt_set(cnt_set_b), .cnt_dec(cnt_dec_b), .cnt_zero(cnt_zero),
        .sum(sum_b), .done(done_b), .busy(busy_b), .err(err_b)
    );

    // Step counter model: no reset, loads on set, decrements on dec.
    int preset = CNT_PRESET;
    int cnt = 5;
    always @(posedge clk) begin
        if (cnt_set) cnt <= preset;
        else if (cnt_dec) cnt <= cnt - 1;
    end
    assign cnt_zero = (cnt == 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_set, n_dec, n_acc;
    always @(negedge clk) begin
        if (cnt_set) n_set++;
        if (cnt_dec) n_dec++;
        if (in_valid && in_ready) n_acc++;
    end

    typedef struct {
        int s;
        bit e;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int errors = 0;
    int t0;
    int ops[8];

    task automatic do_start();
        @(posedge clk);
        #1;
        n_set = 0;
        n_dec = 0;
        n_acc = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gap, input int start_at);
        int  i = 0;
        int  guard = 0;
        bit  idle = 1'b0;
        bit  took;
        while (i < n && guard < 100) begin
            guard++;
            if (gap && idle) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = 8'(ops[i]);
            end
            start = (i == start_at) && in_valid;
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (took) begin
                i++;
                idle = gap;
            end else if (!in_valid) begin
                idle = 1'b0;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (i != n) begin
            errors++;
            $display("FAIL feed_accepts: got %0d, expected %0d", i, n);
        end
    endtask

    task automatic finish_run(input string name, input int lat, input bit chk_b, input int exp_b);
        exp_t e;
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%0b, expected 1", name, done);
        end
        e = sb.pop_front();
        vectors++;
        if (cyc - t0 !== lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d, expected %0d", name, cyc - t0, lat);
        end
        vectors++;
        if (sum !== 12'(e.s)) begin
            errors++;
            $display("FAIL %s_sum: got %0d, expected %0d", name, sum, e.s);
        end
        vectors++;
        if (err !== e.e) begin
            errors++;
            $display("FAIL %s_err: got %0b, expected %0b", name, err, e.e);
        end
        vectors++;
        if (n_dec !== 7 || n_set !== 1 || n_acc !== 8) begin
            errors++;
            $display("FAIL %s_pulses: dec=%0d set=%0d acc=%0d, expected 7 1 8", name, n_dec, n_set, n_acc);
        end
        if (chk_b) begin
            vectors++;
            if (sum_b !== 10'(exp_b)) begin
                errors++;
                $display("FAIL %s_sum_w10: got %0d, expected %0d", name, sum_b, exp_b);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 12'(e.s) || err !== e.e) begin
            errors++;
            $display("FAIL %s_hold: done=%0b busy=%0b sum=%0d err=%0b", name, done, busy, sum, err);
        end
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if ({sum, done, err, busy, in_ready, cnt_set, cnt_dec} !== '0) begin
            errors++;
            $display("FAIL %s: sum=%0d done=%0b err=%0b busy=%0b rdy=%0b set=%0b dec=%0b, expected all 0",
                     name, sum, done, err, busy, in_ready, cnt_set, cnt_dec);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_values");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) ops[i] = i + 1;
        sb.push_back('{36, 1'b0});
        do_start();
        feed(8, 1'b0, -1);
        finish_run("basic", 10, 1'b0, 0);
    endtask

    task automatic test_max();
        for (int i = 0; i < 8; i++) ops[i] = 255;
        sb.push_back('{2040, 1'b0});
        do_start();
        feed(8, 1'b0, -1);
        finish_run("max", 10, 1'b1, 1016);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 8; i++) ops[i] = 5;
        sb.push_back('{40, 1'b0});
        do_start();
        feed(8, 1'b1, -1);
        finish_run("gaps", 17, 1'b0, 0);
    endtask

    task automatic test_bad_preset();
        for (int i = 0; i < 8; i++) ops[i] = i + 1;
        preset = 9;
        sb.push_back('{36, 1'b1});
        do_start();
        feed(8, 1'b0, -1);
        finish_run("bad_preset", 10, 1'b0, 0);
        preset = CNT_PRESET;
    endtask

    task automatic test_midrun_reset();
        for (int i = 0; i < 8; i++) ops[i] = 1;
        do_start();
        feed(3, 1'b0, -1);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back('{8, 1'b0});
        do_start();
        feed(8, 1'b0, -1);
        finish_run("after_reset", 10, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 8; i++) ops[i] = 3;
        sb.push_back('{24, 1'b0});
        do_start();
        feed(8, 1'b0, 3);
        finish_run("start_in_accum", 10, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) ops[i] = 10 * (i + 1);
        sb.push_back('{360, 1'b0});
        do_start();
        vectors++;
        if (done !== 1'b0 || cnt_set !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: done=%0b set=%0b busy=%0b, expected 0 1 1", done, cnt_set, busy);
        end
        feed(8, 1'b0, -1);
        finish_run("back_to_back", 10, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_gaps();
        test_bad_preset();
        test_midrun_reset();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
